// File: rtl/mmu_pkg.sv
// Shared types for the MMU data-memory port: owner identifiers and the
// byte-enable encodings the MMU accepts on dm_be.
package mmu_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_M0   = 2'd1,
      OWN_M1   = 2'd2
   } owner_e;

   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_B0   = 4'b0001;
   localparam logic [3:0] BE_B1   = 4'b0010;
   localparam logic [3:0] BE_B2   = 4'b0100;
   localparam logic [3:0] BE_B3   = 4'b1000;
   localparam logic [3:0] BE_H0   = 4'b0011;
   localparam logic [3:0] BE_H1   = 4'b1100;
   localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational owner selection for the data-memory port: burst-limited
// round robin between M0 and M1.
module dm_arb_pick
   import mmu_pkg::*;
#(
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned CNT_W     = $clog2(MAX_BURST) + 1
) (
   input  logic             req0,
   input  logic             req1,
   input  owner_e           prev_owner,
   input  owner_e           last_grant,
   input  logic [CNT_W-1:0] burst_cnt,
   output owner_e           owner
);

   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

   logic hold;

   // The current owner may keep the port only while its burst has room left.
   assign hold = (prev_owner != OWN_NONE) && (burst_cnt < BURST_LAST);

   always_comb begin
      owner = OWN_NONE;
      if (req0 && req1) begin
         if (hold) begin
            owner = prev_owner;
         end else if (last_grant == OWN_M0) begin
            owner = OWN_M1;
         end else begin
            owner = OWN_M0;
         end
      end else if (req0) begin
         owner = OWN_M0;
      end else if (req1) begin
         owner = OWN_M1;
      end
   end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the MMU data-memory port between the CPU LSU (M0) and the boot
// loader/DMA (M1); steers each read response back to its requester.
module dm_port_arbiter
   import mmu_pkg::*;
#(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_be,
   input  logic        m0_signed,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_be,
   input  logic        m1_signed,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_di,
   output logic [3:0]  dm_be,
   output logic        is_signed,
   input  logic [31:0] dm_do
);

   localparam int unsigned      CNT_W      = $clog2(MAX_BURST) + 1;
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

   owner_e           pick_owner, owner;
   owner_e           prev_owner_q, prev_owner_d;
   owner_e           last_grant_q, last_grant_d;
   owner_e           resp_owner_q, resp_owner_d;
   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

   dm_arb_pick #(
      .MAX_BURST (MAX_BURST),
      .CNT_W     (CNT_W)
   ) u_pick (
      .req0       (m0_req),
      .req1       (m1_req),
      .prev_owner (prev_owner_q),
      .last_grant (last_grant_q),
      .burst_cnt  (burst_cnt_q),
      .owner      (pick_owner)
   );

   // Reset is synchronous, so grants must also be blocked combinationally.
   assign owner  = resetb ? pick_owner : OWN_NONE;
   assign m0_gnt = (owner == OWN_M0);
   assign m1_gnt = (owner == OWN_M1);

   // NOTE: outputs get defaults first so no path through the case leaves one unassigned (no latch).
   always_comb begin
      dm_we     = 1'b0;
      dm_addr   = '0;
      dm_di     = '0;
      dm_be     = BE_NONE;
      is_signed = 1'b0;
      case (owner)
         OWN_M0: begin
            dm_we     = m0_we;
            dm_addr   = m0_addr;
            dm_di     = m0_wdata;
            dm_be     = m0_be;
            is_signed = m0_signed;
         end
         OWN_M1: begin
            dm_we     = m1_we;
            dm_addr   = m1_addr;
            dm_di     = m1_wdata;
            dm_be     = m1_be;
            is_signed = m1_signed;
         end
         default: ;
      endcase
   end

   always_comb begin
      prev_owner_d = owner;
      last_grant_d = (owner != OWN_NONE) ? owner : last_grant_q;
      burst_cnt_d  = '0;
      if ((owner != OWN_NONE) && (owner == prev_owner_q)) begin
         burst_cnt_d = (burst_cnt_q == BURST_LAST) ? burst_cnt_q : burst_cnt_q + CNT_W'(1);
      end
      resp_owner_d = ((owner != OWN_NONE) && !dm_we) ? owner : OWN_NONE;
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         prev_owner_q <= OWN_NONE;
         last_grant_q <= OWN_M1;
         burst_cnt_q  <= '0;
         resp_owner_q <= OWN_NONE;
      end else begin
         prev_owner_q <= prev_owner_d;
         last_grant_q <= last_grant_d;
         burst_cnt_q  <= burst_cnt_d;
         resp_owner_q <= resp_owner_d;
      end
   end

   // A read granted just before reset must not surface while reset is held.
   assign m0_rvalid = resetb && (resp_owner_q == OWN_M0);
   assign m1_rvalid = resetb && (resp_owner_q == OWN_M1);
   assign m0_rdata  = dm_do;
   assign m1_rdata  = dm_do;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: a directed cycle table on a MAX_BURST=4 instance plus
// randomized traffic on MAX_BURST=4 and MAX_BURST=1 instances against a run-length model.
module tb_dm_port_arbiter;
   import mmu_pkg::*;

   logic        clk;
   logic        resetb;
   logic        m0_req, m0_we, m0_signed;
   logic [31:0] m0_addr, m0_wdata;
   logic [3:0]  m0_be;
   logic        m1_req, m1_we, m1_signed;
   logic [31:0] m1_addr, m1_wdata;
   logic [3:0]  m1_be;
   logic [31:0] dm_do;

   logic        m0_gnt_w [2];
   logic        m1_gnt_w [2];
   logic        m0_rv_w [2];
   logic        m1_rv_w [2];
   logic [31:0] m0_rdata_w [2];
   logic [31:0] m1_rdata_w [2];
   logic        dm_we_w [2];
   logic [31:0] dm_addr_w [2];
   logic [31:0] dm_di_w [2];
   logic [3:0]  dm_be_w [2];
   logic        is_signed_w [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      dm_port_arbiter #(
         .MAX_BURST (g == 0 ? 4 : 1)
      ) u_dut (
         .clk       (clk),
         .resetb    (resetb),
         .m0_req    (m0_req),
         .m0_we     (m0_we),
         .m0_addr   (m0_addr),
         .m0_wdata  (m0_wdata),
         .m0_be     (m0_be),
         .m0_signed (m0_signed),
         .m0_gnt    (m0_gnt_w[g]),
         .m0_rvalid (m0_rv_w[g]),
         .m0_rdata  (m0_rdata_w[g]),
         .m1_req    (m1_req),
         .m1_we     (m1_we),
         .m1_addr   (m1_addr),
         .m1_wdata  (m1_wdata),
         .m1_be     (m1_be),
         .m1_signed (m1_signed),
         .m1_gnt    (m1_gnt_w[g]),
         .m1_rvalid (m1_rv_w[g]),
         .m1_rdata  (m1_rdata_w[g]),
         .dm_we     (dm_we_w[g]),
         .dm_addr   (dm_addr_w[g]),
         .dm_di     (dm_di_w[g]),
         .dm_be     (dm_be_w[g]),
         .is_signed (is_signed_w[g]),
         .dm_do     (dm_do)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Model state: 0 = none, 1 = M0, 2 = M1. run_len counts consecutive grants to run_own.
   int mb [2]      = '{4, 1};
   int run_own [2] = '{0, 0};
   int run_len [2] = '{0, 0};
   int last_g [2]  = '{2, 2};
   int resp [2]    = '{0, 0};
   int exp_own [2] = '{0, 0};

   typedef struct {
      logic       rst_n;
      logic       r0;
      logic       w0;
      logic [3:0] be0;
      logic       r1;
      logic       w1;
      logic [3:0] be1;
      logic [1:0] gnt;   // {m1_gnt, m0_gnt}
      logic [1:0] rv;    // {m1_rvalid, m0_rvalid}
      logic [3:0] dbe;
      logic       dwe;
   } vec_t;

   localparam int NVEC = 29;
   vec_t tbl [NVEC];

   function automatic vec_t mk(logic rst_n, logic r0, logic w0, logic [3:0] be0,
                               logic r1, logic w1, logic [3:0] be1,
                               logic [1:0] gnt, logic [1:0] rv, logic [3:0] dbe, logic dwe);
      vec_t v;
      v.rst_n = rst_n; v.r0 = r0; v.w0 = w0; v.be0 = be0;
      v.r1 = r1; v.w1 = w1; v.be1 = be1;
      v.gnt = gnt; v.rv = rv; v.dbe = dbe; v.dwe = dwe;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [3:0] rand_be();
      case ($urandom_range(0, 6))
         0:       return BE_B0;
         1:       return BE_B1;
         2:       return BE_B2;
         3:       return BE_B3;
         4:       return BE_H0;
         5:       return BE_H1;
         default: return BE_WORD;
      endcase
   endfunction

   // Compare both instances against the model at the negedge.
   task automatic check_model();
      for (int k = 0; k < 2; k++) begin
         int          o;
         logic        e_we, e_sg;
         logic [3:0]  e_be;
         logic [31:0] e_addr, e_di;
         o = 0;
         if (resetb) begin
            if (m0_req && m1_req) begin
               if (run_own[k] != 0 && run_len[k] < mb[k]) o = run_own[k];
               else o = (last_g[k] == 1) ? 2 : 1;
            end else if (m0_req) begin
               o = 1;
            end else if (m1_req) begin
               o = 2;
            end
         end
         exp_own[k] = o;
         e_we = 1'b0; e_sg = 1'b0; e_be = BE_NONE; e_addr = '0; e_di = '0;
         if (o == 1) begin
            e_we = m0_we; e_sg = m0_signed; e_be = m0_be; e_addr = m0_addr; e_di = m0_wdata;
         end else if (o == 2) begin
            e_we = m1_we; e_sg = m1_signed; e_be = m1_be; e_addr = m1_addr; e_di = m1_wdata;
         end
         check($sformatf("mdl%0d_gnt", k), 32'({m1_gnt_w[k], m0_gnt_w[k]}),
               32'({o == 2, o == 1}));
         check($sformatf("mdl%0d_rvalid", k), 32'({m1_rv_w[k], m0_rv_w[k]}),
               32'({resetb && resp[k] == 2, resetb && resp[k] == 1}));
         check($sformatf("mdl%0d_be_we", k), 32'({dm_be_w[k], dm_we_w[k]}), 32'({e_be, e_we}));
         if (o != 0 || !resetb) begin
            check($sformatf("mdl%0d_addr", k), dm_addr_w[k], e_addr);
            check($sformatf("mdl%0d_di", k), dm_di_w[k], e_di);
         end
         if (o != 0) check($sformatf("mdl%0d_signed", k), 32'(is_signed_w[k]), 32'(e_sg));
         check($sformatf("mdl%0d_rdata", k), 32'(m0_rdata_w[k] ^ dm_do) | 32'(m1_rdata_w[k] ^ dm_do), 32'd0);
      end
   endtask

   // Update the model as the clock edge will, then move to just after that edge.
   task automatic advance();
      for (int k = 0; k < 2; k++) begin
         int o;
         o = exp_own[k];
         if (!resetb) begin
            run_own[k] = 0; run_len[k] = 0; last_g[k] = 2; resp[k] = 0;
         end else begin
            if (o != 0 && o == run_own[k]) run_len[k]++;
            else run_len[k] = (o != 0) ? 1 : 0;
            run_own[k] = o;
            if (o != 0) last_g[k] = o;
            resp[k] = (o != 0 && !((o == 1) ? m0_we : m1_we)) ? o : 0;
         end
      end
      @(posedge clk);
      #1;
      dm_do = $urandom;
   endtask

   initial begin
      resetb = 1'b0;
      m0_req = 1'b0; m0_we = 1'b0; m0_be = BE_WORD; m0_signed = 1'b1;
      m0_addr = 32'h0000_0100; m0_wdata = 32'hA5A5_0055;
      m1_req = 1'b0; m1_we = 1'b0; m1_be = BE_WORD; m1_signed = 1'b0;
      m1_addr = 32'h1000_0004; m1_wdata = 32'h5A5A_1234;
      dm_do = 32'hDEAD_BEEF;

      // Reset held with an M0 write pending, then release.
      tbl[0]  = mk(0, 1, 1, BE_WORD, 0, 0, BE_WORD, 2'b00, 2'b00, BE_NONE, 0);
      tbl[1]  = mk(0, 1, 1, BE_WORD, 0, 0, BE_WORD, 2'b00, 2'b00, BE_NONE, 0);
      tbl[2]  = mk(0, 1, 1, BE_WORD, 0, 0, BE_WORD, 2'b00, 2'b00, BE_NONE, 0);
      tbl[3]  = mk(1, 1, 1, BE_WORD, 0, 0, BE_WORD, 2'b01, 2'b00, BE_WORD, 1);
      tbl[4]  = mk(1, 0, 0, BE_WORD, 0, 0, BE_WORD, 2'b00, 2'b00, BE_NONE, 0);
      // Single M1 read, rvalid one cycle later.
      tbl[5]  = mk(1, 0, 0, BE_WORD, 1, 0, BE_WORD, 2'b10, 2'b00, BE_WORD, 0);
      tbl[6]  = mk(1, 0, 0, BE_WORD, 0, 0, BE_WORD, 2'b00, 2'b10, BE_NONE, 0);
      // Contention: four M0 then four M1 then M0.
      tbl[7]  = mk(1, 1, 0, BE_WORD, 1, 0, BE_WORD, 2'b01, 2'b00, BE_WORD, 0);
      tbl[8]  = mk(1, 1, 0, BE_WORD, 1, 0, BE_WORD, 2'b01, 2'b01, BE_WORD, 0);
      tbl[9]  = mk(1, 1, 0, BE_WORD, 1, 0, BE_WORD, 2'b01, 2'b01, BE_WORD, 0);
      tbl[10] = mk(1, 1, 0, BE_WORD, 1, 0, BE_WORD, 2'b01, 2'b01, BE_WORD, 0);
      tbl[11] = mk(1, 1, 0, BE_WORD, 1, 0, BE_WORD, 2'b10, 2'b01, BE_WORD, 0);
      tbl[12] = mk(1, 1, 0, BE_WORD, 1, 0, BE_WORD, 2'b10, 2'b10, BE_WORD, 0);
      tbl[13] = mk(1, 1, 0, BE_WORD, 1, 0, BE_WORD, 2'b10, 2'b10, BE_WORD, 0);
      tbl[14] = mk(1, 1, 0, BE_WORD, 1, 0, BE_WORD, 2'b10, 2'b10, BE_WORD, 0);
      tbl[15] = mk(1, 1, 0, BE_WORD, 1, 0, BE_WORD, 2'b01, 2'b10, BE_WORD, 0);
      // M0 write then M1 read: only one M1 rvalid.
      tbl[16] = mk(1, 1, 1, BE_B1,   0, 0, BE_WORD, 2'b01, 2'b01, BE_B1,   1);
      tbl[17] = mk(1, 0, 0, BE_WORD, 1, 0, BE_WORD, 2'b10, 2'b00, BE_WORD, 0);
      tbl[18] = mk(1, 0, 0, BE_WORD, 0, 0, BE_WORD, 2'b00, 2'b10, BE_NONE, 0);
      tbl[19] = mk(1, 0, 0, BE_WORD, 0, 0, BE_WORD, 2'b00, 2'b00, BE_NONE, 0);
      // Burst break: M0 two reads, gap, then contention goes to M1.
      tbl[20] = mk(1, 1, 0, BE_WORD, 0, 0, BE_WORD, 2'b01, 2'b00, BE_WORD, 0);
      tbl[21] = mk(1, 1, 0, BE_WORD, 0, 0, BE_WORD, 2'b01, 2'b01, BE_WORD, 0);
      tbl[22] = mk(1, 0, 0, BE_WORD, 0, 0, BE_WORD, 2'b00, 2'b01, BE_NONE, 0);
      tbl[23] = mk(1, 1, 0, BE_WORD, 1, 0, BE_WORD, 2'b10, 2'b00, BE_WORD, 0);
      tbl[24] = mk(1, 1, 0, BE_WORD, 1, 0, BE_WORD, 2'b10, 2'b10, BE_WORD, 0);
      // M1 drops mid-burst: immediate hand-over to M0.
      tbl[25] = mk(1, 1, 0, BE_WORD, 0, 0, BE_WORD, 2'b01, 2'b10, BE_WORD, 0);
      // Reset right after an M0 read grant: its rvalid is dropped.
      tbl[26] = mk(0, 1, 0, BE_WORD, 1, 0, BE_WORD, 2'b00, 2'b00, BE_NONE, 0);
      tbl[27] = mk(1, 1, 0, BE_WORD, 1, 0, BE_WORD, 2'b01, 2'b00, BE_WORD, 0);
      tbl[28] = mk(1, 0, 0, BE_WORD, 0, 0, BE_WORD, 2'b00, 2'b01, BE_NONE, 0);

      for (int i = 0; i < NVEC; i++) begin
         resetb = tbl[i].rst_n;
         m0_req = tbl[i].r0; m0_we = tbl[i].w0; m0_be = tbl[i].be0;
         m1_req = tbl[i].r1; m1_we = tbl[i].w1; m1_be = tbl[i].be1;
         @(negedge clk);
         check_model();
         check($sformatf("tbl%0d_gnt", i), 32'({m1_gnt_w[0], m0_gnt_w[0]}), 32'(tbl[i].gnt));
         check($sformatf("tbl%0d_rvalid", i), 32'({m1_rv_w[0], m0_rv_w[0]}), 32'(tbl[i].rv));
         check($sformatf("tbl%0d_be", i), 32'(dm_be_w[0]), 32'(tbl[i].dbe));
         check($sformatf("tbl%0d_we", i), 32'(dm_we_w[0]), 32'(tbl[i].dwe));
         advance();
      end

      // Random traffic; a pending request keeps its fields until instance 0 grants it.
      for (int c = 0; c < 3000; c++) begin
         resetb = ($urandom_range(0, 199) != 0);
         if (!(m0_req && exp_own[0] != 1)) begin
            m0_req = ($urandom_range(0, 99) < 65);
            m0_we = 1'($urandom_range(0, 1)); m0_addr = $urandom; m0_wdata = $urandom;
            m0_be = rand_be(); m0_signed = 1'($urandom_range(0, 1));
         end
         if (!(m1_req && exp_own[0] != 2)) begin
            m1_req = ($urandom_range(0, 99) < 65);
            m1_we = 1'($urandom_range(0, 1)); m1_addr = $urandom; m1_wdata = $urandom;
            m1_be = rand_be(); m1_signed = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         check_model();
         advance();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
